// File: rtl/hazard_sched.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use stall and branch flush.
// Forwarding is built only with HAZARD_FWD_EN; otherwise RAW hazards stall until the producer reaches W.
module hazard_sched (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic [4:0] rdD,
  input  logic       RegWriteD,
  input  logic       MemLoadD,
  input  logic       PCSrcE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE
);

  logic [4:0] rs1_e, rs2_e, rd_e;
  logic       reg_write_e, load_e;
  logic [4:0] rd_m;
  logic       reg_write_m;
  logic [4:0] rd_w;
  logic       reg_write_w;
  logic       hazard_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd_e        <= '0;
      reg_write_e <= 1'b0;
      load_e      <= 1'b0;
      rd_m        <= '0;
      reg_write_m <= 1'b0;
      rd_w        <= '0;
      reg_write_w <= 1'b0;
    end else begin
      if (FlushE) begin
        rs1_e       <= '0;
        rs2_e       <= '0;
        rd_e        <= '0;
        reg_write_e <= 1'b0;
        load_e      <= 1'b0;
      end else begin
        rs1_e       <= rs1D;
        rs2_e       <= rs2D;
        rd_e        <= rdD;
        reg_write_e <= RegWriteD;
        load_e      <= MemLoadD;
      end
      rd_m        <= rd_e;
      reg_write_m <= reg_write_e;
      rd_w        <= rd_m;
      reg_write_w <= reg_write_m;
    end
  end

`ifdef HAZARD_FWD_EN
  logic unused_shadow;
  assign unused_shadow = reg_write_e;

  // Memory-stage match wins over Writeback: it holds the younger value.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rs1_e != '0 && reg_write_m && rs1_e == rd_m)
      ForwardAE = 2'b10;
    else if (rs1_e != '0 && reg_write_w && rs1_e == rd_w)
      ForwardAE = 2'b01;
    if (rs2_e != '0 && reg_write_m && rs2_e == rd_m)
      ForwardBE = 2'b10;
    else if (rs2_e != '0 && reg_write_w && rs2_e == rd_w)
      ForwardBE = 2'b01;
  end

  always_comb begin
    hazard_stall = load_e && (rd_e != '0) && (rd_e == rs1D || rd_e == rs2D);
  end
`else
  logic unused_shadow;
  assign unused_shadow = ^{rs1_e, rs2_e, load_e, rd_w, reg_write_w};

  assign ForwardAE = 2'b00;
  assign ForwardBE = 2'b00;

  // Register file is write-first, so a producer in W is already readable in D.
  always_comb begin
    hazard_stall = 1'b0;
    if (rs1D != '0 && ((reg_write_e && rs1D == rd_e) || (reg_write_m && rs1D == rd_m)))
      hazard_stall = 1'b1;
    if (rs2D != '0 && ((reg_write_e && rs2D == rd_e) || (reg_write_m && rs2D == rd_m)))
      hazard_stall = 1'b1;
  end
`endif

  // A taken branch makes the Decode instruction wrong-path, so the stall is dropped.
  always_comb begin
    StallF = hazard_stall & ~PCSrcE;
    StallD = hazard_stall & ~PCSrcE;
    FlushD = PCSrcE;
    FlushE = hazard_stall | PCSrcE;
  end

endmodule

// File: doc/hazard_sched.md
HAZARD_SCHED -- requirements
Module: hazard_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports rs1D and rs2D, input, 5 bits each: source register numbers of the instruction in Decode.
REQ-004 SHALL have port rdD, input, 5 bits: destination register of the Decode instruction.
REQ-005 SHALL have port RegWriteD, input, 1 bit: Decode instruction writes rdD.
REQ-006 SHALL have port MemLoadD, input, 1 bit: Decode instruction is a load.
REQ-007 SHALL have port PCSrcE, input, 1 bit: branch or jump taken, resolved in Execute.
REQ-008 SHALL have ports ForwardAE and ForwardBE, output, 2 bits each: selects for the Execute-stage 3:1 operand muxes (00 register file, 01 Writeback result, 10 Memory-stage ALU result; 11 never driven).
REQ-009 SHALL have ports StallF and StallD, output, 1 bit each: hold the PC and the IF/ID register.
REQ-010 SHALL have ports FlushD and FlushE, output, 1 bit each: clear the IF/ID and ID/EX registers to a bubble.

Function
REQ-011 SHALL hold a shadow pipeline: E stage (rs1E, rs2E, rdE, RegWriteE, LoadE), M stage (rdM, RegWriteM) and W stage (rdW, RegWriteW).
REQ-012 SHALL load E from the D inputs every cycle, or clear E to all-zero when FlushE=1.
REQ-013 SHALL copy E to M and M to W every cycle, unconditionally.
REQ-014 SHALL compute all outputs combinationally from shadow state and current inputs, with zero added latency.
REQ-015 SHALL drive ForwardAE=10 when rs1E!=0, rs1E==rdM and RegWriteM=1.
REQ-016 SHALL otherwise drive ForwardAE=01 when rs1E!=0, rs1E==rdW and RegWriteW=1; else 00. The M match takes priority over the W match.
REQ-017 SHALL compute ForwardBE identically, using rs2E.
REQ-018 SHALL detect a load-use hazard: lwStall=1 when LoadE=1, rdE!=0 and rdE equals rs1D or rs2D.
REQ-019 SHALL set StallF=StallD=lwStall & ~PCSrcE; a taken branch cancels the stall because the Decode instruction is wrong-path.
REQ-020 SHALL set FlushD=PCSrcE and FlushE=lwStall | PCSrcE.
REQ-021 SHALL never forward, stall or match on register x0.
REQ-022 SHALL, while a stall is held, re-evaluate hazards each cycle; the stall lasts exactly one cycle per load-use pair.

Reset
REQ-023 SHALL clear all shadow registers to 0 on the first rising edge with reset=1.
REQ-024 SHALL therefore drive all outputs to 0 during reset, apart from a combinational dependence on PCSrcE.
REQ-025 SHALL discard any in-progress hazard when reset is applied mid-stall; no stall is asserted in the cycle after reset deasserts unless the new inputs create one.

Configuration
REQ-026 SHALL compile forwarding in only when macro HAZARD_FWD_EN is defined.
REQ-027 With HAZARD_FWD_EN defined, SHALL implement REQ-015 to REQ-020 as written.
REQ-028 Without HAZARD_FWD_EN, SHALL tie ForwardAE and ForwardBE to 00.
REQ-029 Without HAZARD_FWD_EN, SHALL define rawStall=1 when a nonzero rs1D or rs2D equals rdE with RegWriteE=1, or rdM with RegWriteM=1. The W stage needs no stall because the register file is write-first.
REQ-030 Without HAZARD_FWD_EN, SHALL use rawStall in place of lwStall in REQ-019 and REQ-020.

Verification
REQ-031 Reset: hold reset 2 cycles with arbitrary D inputs -> all outputs 0, shadow state 0.
REQ-032 ALU-to-ALU: add x5 in D, then next instr rs1D=5 -> one cycle later ForwardAE=10; the following instr with rs2D=5 -> ForwardBE=01. No stall.
REQ-033 Load-use: load rdD=7, then rs1D=7 -> StallF=StallD=FlushE=1 for exactly 1 cycle. Then ForwardAE=01 when the dependent instruction reaches E.
REQ-034 x0: RegWriteD=1, rdD=0, followed by rs1D=0 -> ForwardAE=00 and no stall, throughout.
REQ-035 Branch during load-use: LoadE with rdE=3, rs1D=3 and PCSrcE=1 in the same cycle -> FlushD=1, FlushE=1, StallF=StallD=0.
REQ-036 Without HAZARD_FWD_EN: add x9 then rs1D=9 -> stall 2 consecutive cycles, Forward outputs 00 throughout.
